// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: LC-3 memory-side responder with wait states, RAM and KBSR/KBDR/DSR/DDR devices.
module lc3_mem_responder #(
  parameter int AW      = 12,
  parameter int LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CS,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] DataIn,
  output logic [15:0] out,
  output logic        ready,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic [7:0]  dd_data,
  output logic        dd_valid,
  input  logic        dd_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [15:0] a, d;
  logic w, kbsr, dsr, commit, io, rd_kbdr, wr_ddr, accept;
  logic [7:0] kbdr;
  logic [15:0] rdata;
  logic [15:0] mem [2**AW];
  always_comb begin
    accept   = state == IDLE && CS;
    commit   = state == BUSY && cnt == 4'd0;
    state_nx = state == IDLE ? (CS ? BUSY : IDLE) : state == BUSY ? (commit ? DONE : BUSY) : IDLE;
    ready    = state == DONE;
    io       = &a[15:9];
    rdata    = !io             ? mem[a[AW-1:0]] :
               a == 16'hFE00   ? {kbsr, 15'b0} :
               a == 16'hFE02   ? {8'b0, kbdr} :
               a == 16'hFE04   ? {dsr, 15'b0} :
               a == 16'hFE06   ? {8'b0, dd_data} : 16'h0000;
    rd_kbdr  = commit && !w && a == 16'hFE02;
    wr_ddr   = commit && w && a == 16'hFE06 && dsr;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      a        <= 16'h0000;
      d        <= 16'h0000;
      w        <= 1'b0;
      out      <= 16'h0000;
      kbsr     <= 1'b0;
      kbdr     <= 8'h00;
      dsr      <= 1'b1;
      dd_valid <= 1'b0;
      dd_data  <= 8'h00;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
        a   <= ADDR;
        d   <= DataIn;
        w   <= WE;
      end else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit && !w) out <= rdata;
      // A fresh keystroke beats the read-clear of the status bit
      if (kb_valid) begin
        kbsr <= 1'b1;
        kbdr <= kb_data;
      end else if (rd_kbdr) kbsr <= 1'b0;
      // A completing display handshake drops any DDR write in the same edge
      if (dd_valid && dd_ready) begin
        dd_valid <= 1'b0;
        dsr      <= 1'b1;
      end else if (wr_ddr) begin
        dd_data  <= d[7:0];
        dd_valid <= 1'b1;
        dsr      <= 1'b0;
      end
    end
  end
  always_ff @(posedge CLK) if (commit && w && !io) mem[a[AW-1:0]] <= d;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed self-checking bench for lc3_mem_responder.
module tb_lc3_mem_responder;
  localparam int LAT = 3;
  logic CLK = 0, RST_N = 0, CS = 0, WE = 0, kb_valid = 0, dd_ready = 0;
  logic [15:0] ADDR = 0, DataIn = 0, out;
  logic [7:0] kb_data = 0, dd_data;
  logic ready, dd_valid, kb_at_commit = 0;
  int n_checks = 0, n_fail = 0;
  logic [15:0] rd;
  int lat, pulses;
  lc3_mem_responder #(.AW(12), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .WE(WE), .ADDR(ADDR), .DataIn(DataIn),
    .out(out), .ready(ready), .kb_data(kb_data), .kb_valid(kb_valid),
    .dd_data(dd_data), .dd_valid(dd_valid), .dd_ready(dd_ready)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] din,
                        input logic [7:0] kbd, output logic [15:0] r, output int l);
    @(negedge CLK);
    CS = 1; WE = we; ADDR = addr; DataIn = din;
    @(posedge CLK);
    #1 CS = 0;
    l = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      kb_valid = kb_at_commit && c == LAT;
      if (kb_valid) kb_data = kbd;
      if (ready) begin
        l = c;
        break;
      end
    end
    kb_valid = 0;
    r = out;
  endtask
  task automatic wr(input logic [15:0] addr, input logic [15:0] din);
    access(1'b1, addr, din, 8'h00, rd, lat);
    check("wr_latency", 16'(lat), 16'(LAT + 1));
  endtask
  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    access(1'b0, addr, 16'h0000, 8'h00, rd, lat);
    check({tag, "_lat"}, 16'(lat), 16'(LAT + 1));
    check(tag, rd, exp);
  endtask
  task automatic kb_pulse(input logic [7:0] ch);
    @(negedge CLK);
    kb_valid = 1; kb_data = ch;
    @(negedge CLK);
    kb_valid = 0;
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    check("rst_ready", {15'b0, ready}, 16'h0000);
    check("rst_out", out, 16'h0000);
    check("rst_dd_valid", {15'b0, dd_valid}, 16'h0000);
    RST_N = 1;
    wr(16'h3000, 16'h1234);
    rd_chk("ram_rd", 16'h3000, 16'h1234);
    wr(16'h3000, 16'hBEEF);
    rd_chk("alias_rd", 16'h7000, 16'hBEEF);
    rd_chk("io_other", 16'hFE10, 16'h0000);
    kb_pulse(8'h41);
    rd_chk("kbsr_set", 16'hFE00, 16'h8000);
    rd_chk("kbdr", 16'hFE02, 16'h0041);
    rd_chk("kbsr_clr", 16'hFE00, 16'h0000);
    rd_chk("dsr_idle", 16'hFE04, 16'h8000);
    wr(16'hFE06, 16'h0058);
    check("dd_valid_set", {15'b0, dd_valid}, 16'h0001);
    check("dd_data", {8'h00, dd_data}, 16'h0058);
    rd_chk("dsr_busy", 16'hFE04, 16'h0000);
    wr(16'hFE06, 16'h0059);
    check("ddr_drop", {8'h00, dd_data}, 16'h0058);
    rd_chk("ddr_rd", 16'hFE06, 16'h0058);
    @(negedge CLK) dd_ready = 1;
    @(negedge CLK);
    check("dd_valid_clr", {15'b0, dd_valid}, 16'h0000);
    dd_ready = 0;
    rd_chk("dsr_ready", 16'hFE04, 16'h8000);
    wr(16'h4002, 16'h0BAD);
    @(negedge CLK);
    CS = 1; WE = 1; ADDR = 16'h4000; DataIn = 16'h1111;
    @(posedge CLK);
    #1 CS = 0;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      CS = c == 1 || c == 3;
      ADDR = c < 3 ? 16'h4002 : 16'h4003;
      DataIn = 16'h2222;
      if (ready) pulses++;
      if (c == LAT + 1) check("busy_ready_pos", {15'b0, ready}, 16'h0001);
    end
    CS = 0;
    check("busy_one_pulse", 16'(pulses), 16'h0001);
    rd_chk("busy_target", 16'h4000, 16'h1111);
    rd_chk("busy_ignored", 16'h4002, 16'h0BAD);
    wr(16'h4001, 16'hAAAA);
    @(negedge CLK);
    CS = 1; WE = 1; ADDR = 16'h4001; DataIn = 16'h5555;
    @(posedge CLK);
    #1 CS = 0;
    @(negedge CLK) RST_N = 0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (c == 1) RST_N = 1;
      if (ready) pulses++;
    end
    check("abort_no_ready", 16'(pulses), 16'h0000);
    check("abort_out_rst", out, 16'h0000);
    rd_chk("abort_ram", 16'h4001, 16'hAAAA);
    kb_pulse(8'h41);
    kb_at_commit = 1;
    access(1'b0, 16'hFE02, 16'h0000, 8'h42, rd, lat);
    kb_at_commit = 0;
    check("kb_race_lat", 16'(lat), 16'(LAT + 1));
    check("kb_race_old", rd, 16'h0041);
    rd_chk("kb_race_kbsr", 16'hFE00, 16'h8000);
    rd_chk("kb_race_kbdr", 16'hFE02, 16'h0042);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
